// File: rtl/game_score_display.sv
// game_score_display: iterative double-dabble score-to-BCD converter driving a multiplexed 4-digit 7-segment display.
// Optional leading-zero blanking: define GAME_SCORE_BLANK_LEADING_ZEROS_EN.
module game_score_display #(
    parameter int SCORE_WIDTH           = 16,
    parameter int REFRESH_COUNTER_WIDTH = 16,
    parameter int MAX_DISPLAY           = 9999
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SCORE_WIDTH-1:0] score,
    output logic [7:0]             abcdefgh,
    output logic [3:0]             digit,
    output logic                   busy,
    output logic                   overflow
);
    localparam int BW = (SCORE_WIDTH > 1) ? $clog2(SCORE_WIDTH) : 1;
    localparam logic [SCORE_WIDTH-1:0] MAX_V = SCORE_WIDTH'(MAX_DISPLAY);

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t                     state_q, state_d;
    logic [SCORE_WIDTH-1:0]     bin_q, bin_d, pending_q, pending_d, shown_q, shown_d;
    logic [15:0]                work_q, work_d, bcd_q, bcd_d, adj;
    logic [BW-1:0]              bit_q, bit_d;
    logic                       ovf_pend_q, ovf_pend_d, overflow_q, overflow_d;
    logic [REFRESH_COUNTER_WIDTH-1:0] cnt_q;
    logic [1:0]                 idx_q, idx_d;
    logic [3:0]                 digit_q, nib;
    logic [7:0]                 seg_q;
    logic                       blank;

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    return 8'b0000_0011;
            4'd1:    return 8'b1001_1111;
            4'd2:    return 8'b0010_0101;
            4'd3:    return 8'b0000_1101;
            4'd4:    return 8'b1001_1001;
            4'd5:    return 8'b0100_1001;
            4'd6:    return 8'b0100_0001;
            4'd7:    return 8'b0001_1111;
            4'd8:    return 8'b0000_0001;
            4'd9:    return 8'b0000_1001;
            default: return 8'hFF;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        work_d     = work_q;
        bit_d      = bit_q;
        pending_d  = pending_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        shown_d    = shown_q;
        overflow_d = overflow_q;
        adj        = work_q;
        for (int i = 0; i < 4; i++)
            if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
        if (state_q == IDLE) begin
            // Unclamped compare so a saturated score converts once, then idles
            if (score != shown_q) begin
                state_d    = CONVERT;
                bin_d      = (score > MAX_V) ? MAX_V : score;
                work_d     = 16'd0;
                pending_d  = score;
                ovf_pend_d = score > MAX_V;
                bit_d      = '0;
            end
        end else begin
            work_d = {adj[14:0], bin_q[SCORE_WIDTH-1]};
            bin_d  = bin_q << 1;
            bit_d  = bit_q + 1'b1;
            if (bit_q == BW'(SCORE_WIDTH-1)) begin
                state_d    = IDLE;
                bcd_d      = work_d;
                shown_d    = pending_q;
                overflow_d = ovf_pend_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            work_q     <= '0;
            bit_q      <= '0;
            pending_q  <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            shown_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            work_q     <= work_d;
            bit_q      <= bit_d;
            pending_q  <= pending_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            shown_q    <= shown_d;
            overflow_q <= overflow_d;
        end
    end

    assign idx_d = (&cnt_q) ? idx_q + 2'd1 : idx_q;
    assign nib   = bcd_q[4*idx_d +: 4];
`ifdef GAME_SCORE_BLANK_LEADING_ZEROS_EN
    assign blank = (idx_d != 2'd0) && ((bcd_q >> {idx_d, 2'b00}) == 16'd0);
`else
    assign blank = 1'b0;
`endif

    // Digit enable and segments come from the same next index so they switch together
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            digit_q <= 4'b1110;
            seg_q   <= 8'b0000_0011;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
            idx_q   <= idx_d;
            digit_q <= ~(4'b0001 << idx_d);
            seg_q   <= blank ? 8'hFF : seg_of(nib);
        end
    end

    assign busy     = (state_q == CONVERT);
    assign overflow = overflow_q;
    assign digit    = digit_q;
    assign abcdefgh = seg_q;
endmodule

// File: tb/tb_game_score_display.sv
// tb_game_score_display: randomized and directed checks against a decimal-arithmetic display model.
module tb_game_score_display;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] score = 16'd0;
    logic [7:0]  abcdefgh;
    logic [3:0]  digit;
    logic        busy, overflow;
    int          errors = 0, checks = 0;
    int          k = 0;
    int          disp_val = 0;
    logic [7:0]  glyph [10] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001,
                                8'b01001001, 8'b01000001, 8'b00011111, 8'b00000001, 8'b00001001};
    int          pow10 [4] = '{1, 10, 100, 1000};

    game_score_display #(.SCORE_WIDTH(16), .REFRESH_COUNTER_WIDTH(2), .MAX_DISPLAY(9999)) dut (
        .clk(clk), .rst(rst), .score(score), .abcdefgh(abcdefgh),
        .digit(digit), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;
    // Cycles since the last reset edge; the scanned digit advances every 4 of them
    always @(posedge clk) k <= rst ? 0 : k + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_idx();
        return (k / 4) % 4;
    endfunction

    function automatic logic [3:0] exp_dig();
        return ~(4'b0001 << exp_idx());
    endfunction

    function automatic logic [7:0] exp_seg(input int val);
        int idx = exp_idx();
`ifdef GAME_SCORE_BLANK_LEADING_ZEROS_EN
        if (idx > 0 && val < pow10[idx]) return 8'hFF;
`endif
        return glyph[(val / pow10[idx]) % 10];
    endfunction

    task automatic wait_conv(output int len);
        len = 0;
        for (int i = 0; i < 40 && !busy; i++) tick();
        while (busy && len < 40) begin
            len++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        score = 16'd0;
        tick();
        tick();
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        if (digit !== 4'b1110) begin errors++; $display("FAIL reset_digit: got %b expected 1110", digit); end
        if (abcdefgh !== 8'b00000011) begin errors++; $display("FAIL reset_seg: got %b expected 00000011", abcdefgh); end
        rst = 1'b0;
        disp_val = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks += 3;
            if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
            if (digit !== exp_dig()) begin errors++; $display("FAIL scan_digit: got %b expected %b", digit, exp_dig()); end
            if (abcdefgh !== exp_seg(0)) begin errors++; $display("FAIL scan_zero: got %b expected %b", abcdefgh, exp_seg(0)); end
        end
    endtask

    task automatic test_value(input int val);
        int len;
        score = 16'(val);
        wait_conv(len);
        checks++;
        if (len !== 16) begin errors++; $display("FAIL busy_len(%0d): got %0d expected 16", val, len); end
        disp_val = (val > 9999) ? 9999 : val;
        tick();
        tick();
        checks++;
        if (overflow !== (val > 9999)) begin errors++; $display("FAIL ovf(%0d): got %b expected %b", val, overflow, val > 9999); end
        for (int i = 0; i < 16; i++) begin
            tick();
            checks += 2;
            if (digit !== exp_dig()) begin errors++; $display("FAIL digit(%0d): got %b expected %b", val, digit, exp_dig()); end
            if (abcdefgh !== exp_seg(disp_val)) begin errors++; $display("FAIL seg(%0d): got %b expected %b", val, abcdefgh, exp_seg(disp_val)); end
        end
    endtask

    task automatic test_overflow();
        bit seen = 0;
        test_value(12345);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL ovf_reconvert: got busy pulse expected none"); end
    endtask

    task automatic test_back_to_back();
        int len1 = 0, len2 = 0;
        score = 16'd5;
        for (int i = 0; i < 40 && !busy; i++) tick();
        while (busy && len1 < 40) begin
            len1++;
            if (len1 == 3) score = 16'd77;
            tick();
        end
        checks += 3;
        if (len1 !== 16) begin errors++; $display("FAIL b2b_len1: got %0d expected 16", len1); end
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b expected 0", busy); end
        tick();
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b expected 1", busy); end
        checks++;
        if (abcdefgh !== exp_seg(5)) begin errors++; $display("FAIL b2b_first: got %b expected %b", abcdefgh, exp_seg(5)); end
        while (busy && len2 < 40) begin
            len2++;
            tick();
        end
        checks++;
        if (len2 !== 16) begin errors++; $display("FAIL b2b_len2: got %0d expected 16", len2); end
        disp_val = 77;
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (abcdefgh !== exp_seg(77)) begin errors++; $display("FAIL b2b_seg: got %b expected %b", abcdefgh, exp_seg(77)); end
        end
    endtask

    task automatic test_reset_mid();
        score = 16'd4321;
        for (int i = 0; i < 40 && !busy; i++) tick();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        if (digit !== 4'b1110) begin errors++; $display("FAIL rstmid_digit: got %b expected 1110", digit); end
        if (abcdefgh !== 8'b00000011) begin errors++; $display("FAIL rstmid_seg: got %b expected 00000011", abcdefgh); end
        test_value(4321);
    endtask

    task automatic test_random();
        int prev = 4321;
        for (int n = 0; n < 8; n++) begin
            int v = int'($urandom_range(0, 20000));
            if (v == prev) v = v + 1;
            test_value(v);
            prev = v;
        end
    endtask

    initial begin
        test_reset();
        test_value(1234);
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_value(42);
        test_value(7);
        test_value(9999);
        test_value(10000);
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/game_score_display.md
Name: game_score_display

Overview:
- Consumer end of the game's 16-bit target score output: samples the score, converts it to BCD with an iterative double-dabble FSM, and drives a multiplexed 4-digit 7-segment display.
- Sits beside the game top in the board wrapper, fed by the score counter, and outputs directly to board segment/digit pins.
- Display refresh runs continuously, independent of conversion.

Parameters:
- score_width, 16, width of the incoming binary score.
- refresh_counter_width, 16, width of the free-running scan counter; the digit advances on each wrap (2**width cycles per digit).
- max_display, 9999, saturation value (4 digits).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- score  input  score_width  binary score from game logic
- abcdefgh  output  8  segments, active-low; bit7=a … bit1=g, bit0=h (dp)
- digit  output  4  digit enables, active-low one-hot; bit0 = least significant digit
- busy  output  1  high while a conversion is in progress
- overflow  output  1  high while the displayed value is saturated (last converted score > max_display)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (edge with rst=1), values next cycle:
  - state=IDLE, busy=0, overflow=0
  - bcd_q=16'h0000, shown_bin=0
  - scan counter=0, digit index=0, digit=4'b1110
  - abcdefgh=8'b0000_0011 (glyph '0')
- rst mid-conversion aborts it; no partial result is written.
- FSM states:
  - IDLE: on an edge with score != shown_bin:
    - capture clamped value (score > max_display ? max_display : score) into shift register
    - capture score into pending_bin
    - latch ovf_pending = (score > max_display)
    - bit counter=0, go to CONVERT
    - Edge with score == shown_bin: remain IDLE.
  - CONVERT: each edge, add 3 to every BCD nibble >= 5, then shift left one bit (binary MSB into BCD LSB), bit counter+1.
    - On the edge where bit counter==score_width-1 (the 16th CONVERT edge): bcd_q <= result, shown_bin <= pending_bin, overflow <= ovf_pending, go to IDLE.
- busy = (state==CONVERT); combinational from state, high for exactly score_width cycles.
- Latency: load edge L; bcd_q/overflow visible after edge L+16.
- Score changing during CONVERT is ignored. Next IDLE cycle detects the mismatch and starts a new conversion, so the final displayed value always converges to the last stable score.
- Comparison uses the unclamped score, so a score held above max_display converts once and then stays idle.
- Scan:
  - Counter increments every cycle and wraps at 2**refresh_counter_width.
  - On wrap, digit index goes 0→1→2→3→0.
  - digit = ~(1<<index), registered together with abcdefgh, so both change on the same edge.
  - Segment decode of bcd_q nibble[index], active-low, standard glyphs 0–9; nibble values 10–15 (unreachable) decode to all-off 8'hFF.
  - dp (bit0) is always 1 (off).

Optional Feature:
- Macro: GAME_SCORE_BLANK_LEADING_ZEROS_EN.
- Defined: digits 3..1 holding 0 with all higher digits 0 output abcdefgh=8'hFF (blank); digit 0 always shown. Blanking is evaluated from bcd_q in the same cycle as decode, so there is no extra latency.
- Undefined: all four digits always shown, including leading zeros.

Test Plan:
- Reset with score=0, refresh_counter_width=2 -> busy stays 0; digit cycles 1110,1101,1011,0111 every 4 clocks; abcdefgh=8'b00000011 on every digit.
- score 0→1234 held -> busy=1 for exactly 16 cycles; after edge L+16, digits 0..3 show 4,3,2,1 (8'b10011001, 8'b00001101, 8'b00100101, 8'b10011111); overflow=0.
- score=12345 -> after conversion digits show 9,9,9,9 (8'b00001001); overflow=1; no further busy pulses while score stays 12345.
- score 5→77 three cycles into a conversion of 5 -> first result shows 0005; immediately afterwards a second 16-cycle busy pulse occurs, ending with 0077.
- rst asserted during CONVERT of 4321 -> next cycle busy=0, display '0000'; after rst deasserts, 4321 converts from scratch.
- With GAME_SCORE_BLANK_LEADING_ZEROS_EN, score=42 -> digits 3,2 = 8'hFF, digit1 = 8'b10011001, digit0 = 8'b00100101; without the macro, digits 3,2 = 8'b00000011.
